dlx_mem_arbiter: RTL

DLX_MEM_ARBITER -- requirements
Module: dlx_mem_arbiter

---
 rtl/dlx_pkg.sv | 29 ++
 rtl/dlx_arb_pick.sv | 50 +++++
 rtl/dlx_mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : dlx_pkg                                                |
// | Description : Shared types and constants for the DLX memory arbiter. |
// |               Word width, arbiter state encoding, error read data.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dlx_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Read data returned to a requester whose access timed out.
  localparam word_t ERR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } dlx_state_e;

  // Plain-vector state constants for FSM code that keeps state as logic.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dlx_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dlx_arb_pick                                           |
// | Description : Fetch/data priority decision with a bounded data       |
// |               streak so fetch cannot starve.                         |
// | Ports       : clock, reset      - clock, sync active-high reset      |
// |               if_req, dm_req    - pending requests                   |
// |               grant_en          - arbiter is able to grant now       |
// |               grant_if/grant_dm - one-hot grant (at most one high)   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dlx_arb_pick
  import dlx_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant_en,
  output logic grant_if,
  output logic grant_dm
);

  localparam int STREAK_W = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  logic [STREAK_W-1:0] dm_streak;
  logic                if_wins;

  // Fetch wins when it is alone, or when data has used up its streak.
  always_comb begin
    if_wins  = if_req & (~dm_req | (dm_streak == STREAK_MAX));
    grant_if = grant_en & if_wins;
    grant_dm = grant_en & dm_req & ~if_wins;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dm_streak <= '0;
    end else if (grant_if) begin
      dm_streak <= '0;
    end else if (grant_dm && (dm_streak != STREAK_MAX)) begin
      dm_streak <= dm_streak + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dlx_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dlx_mem_arbiter                                        |
// | Description : Shares one memory port between the DLX fetch stage     |
// |               and memory stage. IDLE -> BUSY -> RESP per access,     |
// |               with a BUSY timeout that aborts and sets sticky err.   |
// | Ports       : clock, reset            - clock, sync active-high rst  |
// |               if_req/if_addr          - fetch request                |
// |               if_rdata/if_done        - fetch response               |
// |               dm_req/dm_we/dm_addr/dm_wdata - data request           |
// |               dm_rdata/dm_done        - data response                |
// |               mem_req/we/addr/wdata   - registered memory port       |
// |               mem_rdata/mem_ready     - memory response              |
// |               stall                   - pipeline freeze (comb)       |
// |               err                     - sticky timeout flag          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dlx_mem_arbiter
  import dlx_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT_CYC   = 255   // must be >= 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [WORD_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              err
);

  localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  // Counter value in the last BUSY cycle allowed before the abort.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]        state;
  logic [TO_W-1:0]   busy_cnt;
  logic              owner_dm;     // current access belongs to the data side
  logic              grant_if;
  logic              grant_dm;
  logic              busy_end;
  logic [WORD_W-1:0] resp_data;

  dlx_arb_pick #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_pick (
    .clock   (clock),
    .reset   (reset),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .grant_en(state == ST_IDLE),
    .grant_if(grant_if),
    .grant_dm(grant_dm)
  );

  // A ready in the final allowed cycle still counts as a normal completion.
  always_comb begin
    busy_end  = mem_ready | (busy_cnt == TO_LAST);
    resp_data = mem_ready ? mem_rdata : ERR_RDATA;
  end

  assign stall = (if_req & ~if_done) | (dm_req & ~dm_done);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy_cnt  <= '0;
      owner_dm  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy_cnt <= '0;
          if (grant_dm) begin
            owner_dm  <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= ST_BUSY;
          end else if (grant_if) begin
            owner_dm  <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (busy_end) begin
            mem_req <= 1'b0;
            if (owner_dm) begin
              dm_rdata <= resp_data;
              dm_done  <= 1'b1;
            end else begin
              if_rdata <= resp_data;
              if_done  <= 1'b1;
            end
            if (!mem_ready) begin
              err <= 1'b1;
            end
            state <= ST_RESP;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if_done <= 1'b0;
          dm_done <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
